ppi_hs: RTL and testbench
=========================

Name: ppi_hs

Overview:
- Parametrised programmable peripheral interface: next generation of the CPC/Aleste 8255-compatible PPI.
- Adds 8255 mode 1 strobed handshake I/O on groups A and B, on top of mode 0 basic I/O.
- Parametrises data width of ports A and B.
- Sits on the CPU I/O bus beside the existing PPI. It serves printer/expansion peripherals that need latched input and handshaked output with interrupt requests.

Parameters:
- W, 8: data width of ports A and B (bus/odata stay 8 bits; bits above 7 of A/B are written by zero-extension and not readable).
- SYNC, 2: synchroniser depth (flops) on STB_n/ACK_n pins, range 2..3.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cke  in  1  clock enable; all state except reset advances only when cke=1
- addr  in  2  register select: 0=A, 1=B, 2=C, 3=control
- idata  in  8  CPU write data
- odata  out  8  CPU read data, combinational; 8'hFF when not (cs&oe)
- cs, we, oe  in  1 each  chip select, write strobe (action on rising edge of we&cs), read strobe
- ipa/opa  in/out  W  port A pins in/out (opa all ones when A is input)
- ipb/opb  in/out  W  port B pins in/out
- ipc/opc  in/out  8  port C pins; handshake lines are mapped onto C bits in mode 1
- intr_a, intr_b  out  1  registered interrupt requests (copies of PC3/PC0)

Behaviour:
- Reset (async, reset_n=0): mode=8'h9B; opa_r/opb_r/opc_r=0; IBF/OBF/INTR/INTE all 0. All ports are inputs, so opa/opb/opc = all ones, intr_a=intr_b=0.
- Control write, bit7=1: load mode and clear port latches and handshake state. mode[6]=1 (mode 2) is treated as mode 1 for group A.
- Control write, bit7=0: bit set/reset on PC[idata[3:1]].
  - In mode 1, BSR on PC4 (A input), PC6 (A output) or PC2 (B) writes INTE_A/INTE_B instead of the pin latch.
  - Other handshake-owned bits ignore BSR.
- Mode 0: identical to the legacy PPI (direction per mode[4],[3],[1],[0]). A port C write touches only bits not owned by handshakes.
- Mode 1 group A input: STB_n=ipc[4], IBF=opc[5], INTR_A=opc[3].
  - On synchronised falling edge of STB_n: latch ipa into the A input latch and set IBF. If IBF was already set, the latch is overwritten (no stall).
  - On synchronised rising edge of STB_n: set INTR_A if IBF & INTE_A.
  - Read of A: returns the latch. Leading edge of read (cs&oe rising, addr=0) clears INTR_A; trailing edge clears IBF.
- Mode 1 group A output: OBF_n=opc[7], ACK_n=ipc[6], INTR_A=opc[3].
  - CPU write of A: opa_r<=idata, OBF_n<=0, INTR_A<=0.
  - Synchronised ACK_n falling: OBF_n<=1.
  - Synchronised ACK_n rising: INTR_A<=INTE_A.
- Mode 1 group B: same rules. STB_n/ACK_n=ipc[2], IBF/OBF_n=opc[1], INTR_B=opc[0].
- Reading port C: mode 1 returns handshake status in the owned bits (IBF, OBF_n, INTE in place of the STB/ACK pin, INTR). Unowned bits follow mode 0 rules.
- Latency from STB_n/ACK_n pin edge to IBF/OBF_n/INTR update: SYNC+1 cke cycles. ipa/ipb pass through an equally deep pipeline so the latched data is aligned to the strobe.
- Simultaneous events in the same cke cycle:
  - CPU write of A plus ACK edge: the write wins (OBF_n=0).
  - Read-trailing plus STB falling: IBF stays set with the new data.
  - Mode write: overrides everything.
- Reset asserted mid-handshake returns to the reset state immediately. Pin edges seen within SYNC cycles of release are discarded (edge detectors are preset to 1).

Decomposition:
- Shared package ppi_pkg: address constants, control-word bit positions, PC bit indices for handshake lines, reset mode 8'h9B.
- One sub-module ppi_hs_chan, instantiated twice (group A, group B). It holds the synchroniser, edge detect, data latch, IBF/OBF/INTE/INTR state and a direction input. The top module holds the mode register, bus decode, port C merge and the odata mux.

Test Plan:
- Reset release, read addr 3 -> 8'h9B; opa=opb=opc=all ones; intr_a=intr_b=0.
- Mode 0: control 8'h80; write A=8'h5A, C=8'h3C; BSR 8'h0F -> opa=8'h5A, opc=8'hBC.
- A mode 1 input: control 8'hB0, BSR 8'h09 (INTE_A); ipa=8'hC3, pulse ipc[4] low for 4 cycles -> opc[5]=1 after SYNC+1 cycles. intr_a=1 after STB rises. Read A returns 8'hC3, intr_a clears at read start, opc[5] clears at read end.
- A mode 1 output: control 8'hA0, BSR 8'h0D; write A=8'h77 -> opc[7]=0, opa=8'h77. ACK pulse on ipc[6] -> opc[7]=1, then intr_a=1 on the ACK rising edge.
- B mode 1 input with W=12 build: control 8'h86, BSR 8'h05, ipb=12'hABC, strobe ipc[2] -> intr_b=1, read B = 8'hBC; the same strobe while IBF set overwrites data with no error.
- Reset_n pulsed low mid-handshake (IBF=1) -> IBF/INTR cleared and mode=8'h9B asynchronously. A strobe edge within 2 cycles after release is ignored.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared constants for the handshaking PPI: bus addresses, control-word bits,
// port C handshake line positions and the handshake ownership mask.
package ppi_pkg;

    localparam logic [1:0] ADDR_A   = 2'd0;
    localparam logic [1:0] ADDR_B   = 2'd1;
    localparam logic [1:0] ADDR_C   = 2'd2;
    localparam logic [1:0] ADDR_CTL = 2'd3;

    localparam logic [7:0] MODE_RST = 8'h9B;

    localparam int CW_MODE_SET = 7;
    localparam int CW_A_M2     = 6;
    localparam int CW_A_M1     = 5;
    localparam int CW_A_IN     = 4;
    localparam int CW_CU_IN    = 3;
    localparam int CW_B_M1     = 2;
    localparam int CW_B_IN     = 1;
    localparam int CW_CL_IN    = 0;

    localparam int PC_INTR_A = 3;
    localparam int PC_STB_A  = 4;
    localparam int PC_IBF_A  = 5;
    localparam int PC_ACK_A  = 6;
    localparam int PC_OBF_A  = 7;
    localparam int PC_INTR_B = 0;
    localparam int PC_IBF_B  = 1;
    localparam int PC_STB_B  = 2;

    // Port C bits taken over by the handshake logic for the current mode.
    function automatic logic [7:0] own_mask(input logic a_hs, input logic a_in,
                                            input logic b_hs);
        logic [7:0] m;
        m = '0;
        if (a_hs) begin
            m[PC_INTR_A] = 1'b1;
            if (a_in) begin
                m[PC_STB_A] = 1'b1;
                m[PC_IBF_A] = 1'b1;
            end else begin
                m[PC_ACK_A] = 1'b1;
                m[PC_OBF_A] = 1'b1;
            end
        end
        if (b_hs) begin
            m[PC_INTR_B] = 1'b1;
            m[PC_IBF_B]  = 1'b1;
            m[PC_STB_B]  = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ppi_hs_chan.sv
// One strobed-handshake group: pin synchroniser, edge detect, aligned data
// pipeline, input latch, output register and IBF/OBF/INTE/INTR state.
module ppi_hs_chan #(
    parameter int W    = 8,
    parameter int SYNC = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         cke_i,
    input  logic         clr_i,
    input  logic         hs_en_i,
    input  logic         dir_in_i,
    input  logic         pin_i,
    input  logic [W-1:0] din_i,
    input  logic         wr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         rd_lead_i,
    input  logic         rd_trail_i,
    input  logic         inte_wr_i,
    input  logic         inte_val_i,
    output logic [W-1:0] dout_o,
    output logic [W-1:0] latch_o,
    output logic         ibf_o,
    output logic         obf_o,
    output logic         inte_o,
    output logic         intr_o
);

    logic [SYNC-1:0] sync_q;
    logic            prev_q;
    logic [2:0]      arm_q;
    logic [W-1:0]    dpipe_q [SYNC];
    logic [W-1:0]    dout_q, dout_d, latch_q, latch_d;
    logic            ibf_q, ibf_d, obf_q, obf_d, inte_q, inte_d, intr_q, intr_d;
    logic            armed, fall, rise;

    // Edges are only honoured once anything sampled near reset release has
    // drained out of the synchroniser.
    assign armed = (arm_q == 3'(2 * SYNC));
    assign fall  = armed & prev_q & ~sync_q[SYNC-1];
    assign rise  = armed & ~prev_q & sync_q[SYNC-1];

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            dpipe_q[0] <= din_i;
            for (int i = 1; i < SYNC; i++) dpipe_q[i] <= dpipe_q[i-1];
        end
    end

    always_comb begin
        dout_d  = dout_q;
        latch_d = latch_q;
        ibf_d   = ibf_q;
        obf_d   = obf_q;
        inte_d  = inte_q;
        intr_d  = intr_q;
        if (wr_i) dout_d = wdata_i;
        if (hs_en_i && dir_in_i) begin
            if (fall) begin
                latch_d = dpipe_q[SYNC-1];
                ibf_d   = 1'b1;
            end else if (rd_trail_i) begin
                ibf_d = 1'b0;
            end
            if (rise && ibf_q && inte_q) intr_d = 1'b1;
            else if (rd_lead_i)          intr_d = 1'b0;
        end else if (hs_en_i) begin
            if (wr_i) begin
                obf_d  = 1'b1;
                intr_d = 1'b0;
            end else begin
                if (fall) obf_d  = 1'b0;
                if (rise) intr_d = inte_q;
            end
        end
        if (inte_wr_i) inte_d = inte_val_i;
        if (clr_i) begin
            dout_d  = '0;
            latch_d = '0;
            ibf_d   = 1'b0;
            obf_d   = 1'b0;
            inte_d  = 1'b0;
            intr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            arm_q   <= '0;
            dout_q  <= '0;
            latch_q <= '0;
            ibf_q   <= 1'b0;
            obf_q   <= 1'b0;
            inte_q  <= 1'b0;
            intr_q  <= 1'b0;
        end else if (cke_i) begin
            sync_q  <= {sync_q[SYNC-2:0], pin_i};
            prev_q  <= sync_q[SYNC-1];
            if (!armed) arm_q <= arm_q + 3'd1;
            dout_q  <= dout_d;
            latch_q <= latch_d;
            ibf_q   <= ibf_d;
            obf_q   <= obf_d;
            inte_q  <= inte_d;
            intr_q  <= intr_d;
        end
    end

    assign dout_o  = dout_q;
    assign latch_o = latch_q;
    assign ibf_o   = ibf_q;
    assign obf_o   = obf_q;
    assign inte_o  = inte_q;
    assign intr_o  = intr_q;

endmodule

// File: rtl/ppi_hs.sv
// 8255-style PPI with mode 0 basic I/O and mode 1 strobed handshakes on groups
// A and B; holds the mode register, bus decode, port C merge and read mux.
module ppi_hs
    import ppi_pkg::*;
#(
    parameter int W    = 8,
    parameter int SYNC = 2
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         cke,
    input  logic [1:0]   addr,
    input  logic [7:0]   idata,
    output logic [7:0]   odata,
    input  logic         cs,
    input  logic         we,
    input  logic         oe,
    input  logic [W-1:0] ipa,
    output logic [W-1:0] opa,
    input  logic [W-1:0] ipb,
    output logic [W-1:0] opb,
    input  logic [7:0]   ipc,
    output logic [7:0]   opc,
    output logic         intr_a,
    output logic         intr_b
);

    logic [7:0]   mode_q, mode_d, opc_q, opc_d, own, c_dir_out, c_out, c_rd;
    logic         we_q, rda_q, rdb_q;
    logic         a_hs, a_in, b_hs, b_in;
    logic         wr_pulse, ctl_wr, mode_set, bsr, rd_a, rd_b;
    logic [2:0]   bsr_bit, inte_pos_a;
    logic         inte_wr_a, inte_wr_b;
    logic [W-1:0] wdata, dout_a, latch_a, dout_b, latch_b;
    logic         ibf_a, obf_a, inte_a, ibf_b, obf_b, inte_b;

    assign a_hs = mode_q[CW_A_M2] | mode_q[CW_A_M1];
    assign a_in = mode_q[CW_A_IN];
    assign b_hs = mode_q[CW_B_M1];
    assign b_in = mode_q[CW_B_IN];
    assign c_dir_out = {{4{~mode_q[CW_CU_IN]}}, {4{~mode_q[CW_CL_IN]}}};
    assign own = own_mask(a_hs, a_in, b_hs);

    assign wr_pulse   = cke & cs & we & ~we_q;
    assign ctl_wr     = wr_pulse & (addr == ADDR_CTL);
    assign mode_set   = ctl_wr & idata[CW_MODE_SET];
    assign bsr        = ctl_wr & ~idata[CW_MODE_SET];
    assign bsr_bit    = idata[3:1];
    assign inte_pos_a = a_in ? 3'(PC_STB_A) : 3'(PC_ACK_A);
    assign inte_wr_a  = bsr & a_hs & (bsr_bit == inte_pos_a);
    assign inte_wr_b  = bsr & b_hs & (bsr_bit == 3'(PC_STB_B));
    assign rd_a       = cs & oe & (addr == ADDR_A);
    assign rd_b       = cs & oe & (addr == ADDR_B);
    assign wdata      = W'(idata);

    always_comb begin
        mode_d = mode_q;
        opc_d  = opc_q;
        if (wr_pulse && addr == ADDR_C) opc_d = (opc_q & own) | (idata & ~own);
        if (mode_set) begin
            mode_d = idata;
            opc_d  = '0;
        end else if (bsr && !own[bsr_bit]) begin
            opc_d[bsr_bit] = idata[0];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= MODE_RST;
            opc_q  <= '0;
            we_q   <= 1'b0;
            rda_q  <= 1'b0;
            rdb_q  <= 1'b0;
        end else if (cke) begin
            mode_q <= mode_d;
            opc_q  <= opc_d;
            we_q   <= cs & we;
            rda_q  <= rd_a;
            rdb_q  <= rd_b;
        end
    end

    ppi_hs_chan #(.W(W), .SYNC(SYNC)) u_chan_a (
        .clk_i(clk_sys), .rst_ni(reset_n), .cke_i(cke), .clr_i(mode_set),
        .hs_en_i(a_hs), .dir_in_i(a_in),
        .pin_i(a_in ? ipc[PC_STB_A] : ipc[PC_ACK_A]), .din_i(ipa),
        .wr_i(wr_pulse & (addr == ADDR_A)), .wdata_i(wdata),
        .rd_lead_i(cke & rd_a & ~rda_q), .rd_trail_i(cke & rda_q & ~rd_a),
        .inte_wr_i(inte_wr_a), .inte_val_i(idata[0]),
        .dout_o(dout_a), .latch_o(latch_a), .ibf_o(ibf_a), .obf_o(obf_a),
        .inte_o(inte_a), .intr_o(intr_a)
    );

    ppi_hs_chan #(.W(W), .SYNC(SYNC)) u_chan_b (
        .clk_i(clk_sys), .rst_ni(reset_n), .cke_i(cke), .clr_i(mode_set),
        .hs_en_i(b_hs), .dir_in_i(b_in),
        .pin_i(ipc[PC_STB_B]), .din_i(ipb),
        .wr_i(wr_pulse & (addr == ADDR_B)), .wdata_i(wdata),
        .rd_lead_i(cke & rd_b & ~rdb_q), .rd_trail_i(cke & rdb_q & ~rd_b),
        .inte_wr_i(inte_wr_b), .inte_val_i(idata[0]),
        .dout_o(dout_b), .latch_o(latch_b), .ibf_o(ibf_b), .obf_o(obf_b),
        .inte_o(inte_b), .intr_o(intr_b)
    );

    // Handshake-owned C bits: pins drive status, reads show INTE on STB/ACK.
    always_comb begin
        c_out = opc_q | ~c_dir_out;
        c_rd  = (opc_q & c_dir_out) | (ipc & ~c_dir_out);
        if (a_hs) begin
            c_out[PC_INTR_A] = intr_a;
            c_rd[PC_INTR_A]  = intr_a;
            if (a_in) begin
                c_out[PC_STB_A] = 1'b1;
                c_rd[PC_STB_A]  = inte_a;
                c_out[PC_IBF_A] = ibf_a;
                c_rd[PC_IBF_A]  = ibf_a;
            end else begin
                c_out[PC_ACK_A] = 1'b1;
                c_rd[PC_ACK_A]  = inte_a;
                c_out[PC_OBF_A] = ~obf_a;
                c_rd[PC_OBF_A]  = ~obf_a;
            end
        end
        if (b_hs) begin
            c_out[PC_INTR_B] = intr_b;
            c_rd[PC_INTR_B]  = intr_b;
            c_out[PC_IBF_B]  = b_in ? ibf_b : ~obf_b;
            c_rd[PC_IBF_B]   = b_in ? ibf_b : ~obf_b;
            c_out[PC_STB_B]  = 1'b1;
            c_rd[PC_STB_B]   = inte_b;
        end
    end

    assign opa = a_in ? '1 : dout_a;
    assign opb = b_in ? '1 : dout_b;
    assign opc = c_out;

    always_comb begin
        odata = 8'hFF;
        if (cs && oe) begin
            case (addr)
                ADDR_A:  odata = a_in ? (a_hs ? latch_a[7:0] : ipa[7:0]) : dout_a[7:0];
                ADDR_B:  odata = b_in ? (b_hs ? latch_b[7:0] : ipb[7:0]) : dout_b[7:0];
                ADDR_C:  odata = c_rd;
                default: odata = mode_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ppi_hs.sv
// Directed bench for ppi_hs built with 12-bit A/B ports and a 2-flop synchroniser.
module tb_ppi_hs;

    localparam int W = 12;

    logic         clk_sys = 1'b0;
    logic         reset_n, cke, cs, we, oe;
    logic [1:0]   addr;
    logic [7:0]   idata, odata, ipc, opc;
    logic [W-1:0] ipa, opa, ipb, opb;
    logic         intr_a, intr_b;
    int           n_chk  = 0;
    int           n_fail = 0;

    ppi_hs #(.W(W), .SYNC(2)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .cke(cke), .addr(addr),
        .idata(idata), .odata(odata), .cs(cs), .we(we), .oe(oe),
        .ipa(ipa), .opa(opa), .ipb(ipb), .opb(opb), .ipc(ipc), .opc(opc),
        .intr_a(intr_a), .intr_b(intr_b)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        addr = a; idata = d; cs = 1'b1; we = 1'b1;
        @(negedge clk_sys);
        cs = 1'b0; we = 1'b0;
        @(negedge clk_sys);
    endtask

    // Register read without side effects (control or port C).
    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        addr = a; cs = 1'b1; oe = 1'b1;
        #1 chk(tag, 16'(odata), 16'(exp));
        @(negedge clk_sys);
        cs = 1'b0; oe = 1'b0;
    endtask

    task automatic strobe(input int b);
        ipc[b] = 1'b0;
        cyc(4);
        ipc[b] = 1'b1;
        cyc(3);
    endtask

    initial begin
        reset_n = 1'b0; cke = 1'b1; cs = 1'b0; we = 1'b0; oe = 1'b0;
        addr = 2'd0; idata = 8'h00; ipa = '0; ipb = '0; ipc = 8'hFF;
        cyc(3);
        reset_n = 1'b1;
        cyc(1);

        rd_chk("reset_mode", 2'd3, 8'h9B);
        chk("reset_opa", 16'(opa), 16'hFFF);
        chk("reset_opb", 16'(opb), 16'hFFF);
        chk("reset_opc", 16'(opc), 16'hFF);
        chk("reset_intr_a", 16'(intr_a), 16'h0);
        chk("reset_intr_b", 16'(intr_b), 16'h0);

        // Mode 0, every port an output
        bus_wr(2'd3, 8'h80);
        bus_wr(2'd0, 8'h5A);
        bus_wr(2'd2, 8'h3C);
        bus_wr(2'd3, 8'h0F);
        chk("m0_opa", 16'(opa), 16'h05A);
        chk("m0_opb", 16'(opb), 16'h000);
        chk("m0_opc", 16'(opc), 16'hBC);
        rd_chk("m0_read_c", 2'd2, 8'hBC);

        // Group A mode 1 input
        bus_wr(2'd3, 8'hB0);
        chk("ain_opc_idle", 16'(opc), 16'h10);
        chk("ain_opa", 16'(opa), 16'hFFF);
        rd_chk("ain_read_c_noint", 2'd2, 8'h00);
        bus_wr(2'd3, 8'h09);
        rd_chk("ain_read_c_inte", 2'd2, 8'h10);
        ipa = 12'h0C3;
        ipc[4] = 1'b0;
        cyc(2);
        chk("ain_ibf_early", 16'(opc[5]), 16'h0);
        cyc(1);
        chk("ain_ibf_set", 16'(opc[5]), 16'h1);
        cyc(1);
        ipc[4] = 1'b1;
        cyc(2);
        chk("ain_intr_early", 16'(intr_a), 16'h0);
        cyc(1);
        chk("ain_intr_set", 16'(intr_a), 16'h1);
        chk("ain_opc_pc3", 16'(opc[3]), 16'h1);
        addr = 2'd0; cs = 1'b1; oe = 1'b1;
        #1 chk("ain_read_a", 16'(odata), 16'hC3);
        @(negedge clk_sys);
        chk("ain_intr_lead_clr", 16'(intr_a), 16'h0);
        chk("ain_ibf_held", 16'(opc[5]), 16'h1);
        cs = 1'b0; oe = 1'b0;
        cyc(1);
        chk("ain_ibf_trail_clr", 16'(opc[5]), 16'h0);

        // Group A mode 1 output
        bus_wr(2'd3, 8'hA0);
        chk("aout_opc_idle", 16'(opc), 16'hC0);
        bus_wr(2'd3, 8'h0D);
        bus_wr(2'd0, 8'h77);
        chk("aout_opa", 16'(opa), 16'h077);
        chk("aout_obf_low", 16'(opc), 16'h40);
        ipc[6] = 1'b0;
        cyc(3);
        chk("aout_obf_ack", 16'(opc[7]), 16'h1);
        chk("aout_intr_wait", 16'(intr_a), 16'h0);
        cyc(1);
        ipc[6] = 1'b1;
        cyc(3);
        chk("aout_intr_set", 16'(intr_a), 16'h1);
        rd_chk("aout_read_c", 2'd2, 8'hC8);
        bus_wr(2'd0, 8'h11);
        chk("aout_wr_clr_intr", 16'(intr_a), 16'h0);
        chk("aout_wr_obf", 16'(opc), 16'h40);

        // Group B mode 1 input on the 12-bit port
        bus_wr(2'd3, 8'h86);
        chk("bin_opc_idle", 16'(opc), 16'h04);
        chk("bin_opa_cleared", 16'(opa), 16'h000);
        bus_wr(2'd3, 8'h05);
        ipb = 12'hABC;
        strobe(2);
        chk("bin_intr_set", 16'(intr_b), 16'h1);
        chk("bin_opc_full", 16'(opc), 16'h07);
        addr = 2'd1; cs = 1'b1; oe = 1'b1;
        #1 chk("bin_read_b", 16'(odata), 16'hBC);
        @(negedge clk_sys);
        chk("bin_intr_lead_clr", 16'(intr_b), 16'h0);
        cs = 1'b0; oe = 1'b0;
        cyc(1);
        chk("bin_ibf_clr", 16'(opc[1]), 16'h0);
        ipb = 12'h5A5;
        strobe(2);
        ipb = 12'h123;
        strobe(2);
        chk("bin_ibf_overrun", 16'(opc[1]), 16'h1);
        addr = 2'd1; cs = 1'b1; oe = 1'b1;
        #1 chk("bin_read_overwrite", 16'(odata), 16'h23);
        @(negedge clk_sys);
        cs = 1'b0; oe = 1'b0;
        cyc(1);
        ipb = 12'h0F0;
        strobe(2);
        chk("bin_ibf_before_rst", 16'(opc[1]), 16'h1);

        // Asynchronous reset in the middle of a handshake
        reset_n = 1'b0;
        #1;
        chk("rst_opc", 16'(opc), 16'hFF);
        chk("rst_intr_b", 16'(intr_b), 16'h0);
        addr = 2'd3; cs = 1'b1; oe = 1'b1;
        #1 chk("rst_mode", 16'(odata), 16'h9B);
        cs = 1'b0; oe = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        ipc[2] = 1'b0;
        bus_wr(2'd3, 8'h86);
        cyc(4);
        chk("rst_edge_ignored", 16'(opc), 16'h04);
        ipc[2] = 1'b1;
        cyc(3);
        chk("rst_no_intr", 16'(intr_b), 16'h0);
        bus_wr(2'd3, 8'h05);
        ipb = 12'h0AA;
        strobe(2);
        chk("rst_after_alive", 16'(opc), 16'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
